// File: rtl/key8_debounce_pkg.sv
// Shared constants, FSM state encodings and key-vector helpers for key8_debounce.
package key8_debounce_pkg;

    localparam int unsigned KEY_W          = 8;
    localparam int unsigned CNT_W          = 8;
    localparam int unsigned ST_W           = 3;
    localparam int unsigned DEB_CYCLES_DEF = 4;

    localparam logic [ST_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [ST_W-1:0] ST_DEBOUNCE = 3'd1;
    localparam logic [ST_W-1:0] ST_PRESSED  = 3'd2;
    localparam logic [ST_W-1:0] ST_RELEASE  = 3'd3;
    localparam logic [ST_W-1:0] ST_ERROR    = 3'd4;

    // Number of set bits in a key vector.
    function automatic logic [3:0] popcount8(input logic [KEY_W-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < int'(KEY_W); i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

    function automatic logic is_onehot8(input logic [KEY_W-1:0] v);
        return popcount8(v) == 4'd1;
    endfunction

endpackage

// File: rtl/key8_debounce_if.sv
// Keypad lines in, debounced one-hot digit plus strobe/error out.
interface key8_debounce_if;

    logic k0, k1, k2, k3, k4, k5, k6, k7;
    logic c00d, c11d, c22d, c33d, c44d, c55d, c66d, c77d;
    logic key_stb;
    logic key_err;

    modport master (
        output k0, k1, k2, k3, k4, k5, k6, k7,
        input  c00d, c11d, c22d, c33d, c44d, c55d, c66d, c77d,
        input  key_stb, key_err
    );

    modport slave (
        input  k0, k1, k2, k3, k4, k5, k6, k7,
        output c00d, c11d, c22d, c33d, c44d, c55d, c66d, c77d,
        output key_stb, key_err
    );

endinterface

// File: rtl/key8_debounce_sync2.sv
// Two-flop synchronizer for a vector of independent asynchronous lines.
module key8_debounce_sync2 #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key8_debounce.sv
// Octal keypad debouncer: accepts a single stable key, rejects multi-key
// presses, holds the digit through release bounce and key rollover.
module key8_debounce
    import key8_debounce_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    key8_debounce_if.slave  bus
);

    localparam logic [CNT_W-1:0] DEB_LIM = CNT_W'(DEB_CYCLES);

    logic [KEY_W-1:0] k_raw;
    logic [KEY_W-1:0] s;

    logic [ST_W-1:0]  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [KEY_W-1:0] cand_q, cand_d;
    logic [KEY_W-1:0] c_q, c_d;
    logic             stb_q, stb_d;
    logic             err_q, err_d;

    assign k_raw = {bus.k7, bus.k6, bus.k5, bus.k4, bus.k3, bus.k2, bus.k1, bus.k0};

    key8_debounce_sync2 #(.W(KEY_W)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (k_raw),
        .q     (s)
    );

    // Stable-sample counter saturates at the debounce limit.
    assign cnt_inc = (cnt_q >= DEB_LIM) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            c_q     <= '0;
            stb_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            c_q     <= c_d;
            stb_q   <= stb_d;
            err_q   <= err_d;
        end
    end

    // Next state plus next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        c_d     = c_q;
        stb_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                c_d = '0;
                if (s != '0) begin
                    if (is_onehot8(s)) begin
                        cand_d  = s;
                        cnt_d   = CNT_W'(1);
                        state_d = ST_DEBOUNCE;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_ERROR;
                    end
                end
            end

            ST_DEBOUNCE: begin
                if (s == cand_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == DEB_LIM) begin
                        state_d = ST_PRESSED;
                        c_d     = cand_q;
                        stb_d   = 1'b1;
                    end
                end else if (s == '0) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (is_onehot8(s)) begin
                    cand_d = s;
                    cnt_d  = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                    state_d = ST_ERROR;
                end
            end

            // Extra keys while held are ignored (rollover).
            ST_PRESSED: begin
                if (s == '0) begin
                    cnt_d   = CNT_W'(1);
                    state_d = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                if (s == '0) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == DEB_LIM) begin
                        cnt_d   = '0;
                        c_d     = '0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = ST_PRESSED;
                end
            end

            ST_ERROR: begin
                c_d = '0;
                if (s == '0) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == DEB_LIM) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                cand_d  = '0;
                c_d     = '0;
            end
        endcase

        err_d = (state_d == ST_ERROR);
    end

    assign bus.c00d    = c_q[0];
    assign bus.c11d    = c_q[1];
    assign bus.c22d    = c_q[2];
    assign bus.c33d    = c_q[3];
    assign bus.c44d    = c_q[4];
    assign bus.c55d    = c_q[5];
    assign bus.c66d    = c_q[6];
    assign bus.c77d    = c_q[7];
    assign bus.key_stb = stb_q;
    assign bus.key_err = err_q;

endmodule

// File: tb/tb_key8_debounce.sv
// Directed self-checking bench for key8_debounce with DEB_CYCLES = 4.
module tb_key8_debounce;
    import key8_debounce_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic [7:0] c_obs;

    key8_debounce_if bus ();

    key8_debounce #(.DEB_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign c_obs = {bus.c77d, bus.c66d, bus.c55d, bus.c44d,
                    bus.c33d, bus.c22d, bus.c11d, bus.c00d};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_keys(input logic [7:0] v);
        bus.k0 = v[0]; bus.k1 = v[1]; bus.k2 = v[2]; bus.k3 = v[3];
        bus.k4 = v[4]; bus.k5 = v[5]; bus.k6 = v[6]; bus.k7 = v[7];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Step n cycles; strobe expected only after tick stb_at (0 = never),
    // c-outputs switch from c_before to c_after from tick chg_at on.
    task automatic run_loop(input string tag, input int n, input int stb_at,
                            input logic [7:0] c_before, input logic [7:0] c_after,
                            input int chg_at);
        for (int i = 1; i <= n; i++) begin
            tick();
            check({tag, "_stb"}, 32'(bus.key_stb), 32'(i == stb_at));
            check({tag, "_c"}, 32'(c_obs), 32'((i >= chg_at) ? c_after : c_before));
            check({tag, "_err"}, 32'(bus.key_err), 32'd0);
        end
    endtask

    // Structural invariants checked every cycle.
    always @(negedge clk) begin
        check("c_onehot", 32'(popcount8(c_obs) <= 4'd1), 32'd1);
        check("stb_err_excl", 32'(bus.key_stb & bus.key_err), 32'd0);
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        set_keys(8'h00);
        tick();
        tick();
        check("rst_c", 32'(c_obs), 32'd0);
        check("rst_stb", 32'(bus.key_stb), 32'd0);
        check("rst_err", 32'(bus.key_err), 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Clean press of k3, then clean release.
        set_keys(8'h08);
        run_loop("clean_press", 8, 6, 8'h00, 8'h08, 6);
        set_keys(8'h00);
        run_loop("clean_rel", 8, 0, 8'h08, 8'h00, 6);

        // Bouncing k5: 1,0,1,0 then held.
        set_keys(8'h20); run_loop("bounce_t", 1, 0, 8'h00, 8'h00, 99);
        set_keys(8'h00); run_loop("bounce_t", 1, 0, 8'h00, 8'h00, 99);
        set_keys(8'h20); run_loop("bounce_t", 1, 0, 8'h00, 8'h00, 99);
        set_keys(8'h00); run_loop("bounce_t", 1, 0, 8'h00, 8'h00, 99);
        set_keys(8'h20);
        run_loop("bounce_hold", 8, 6, 8'h00, 8'h20, 6);
        set_keys(8'h00);
        run_loop("bounce_rel", 8, 0, 8'h20, 8'h00, 6);

        // Multi-key k1+k6: error from tick 3, dropping 4 cycles after s==0.
        set_keys(8'h42);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("multi_err", 32'(bus.key_err), 32'(i >= 3));
            check("multi_c", 32'(c_obs), 32'd0);
            check("multi_stb", 32'(bus.key_stb), 32'd0);
        end
        set_keys(8'h00);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("multi_rel_err", 32'(bus.key_err), 32'(i < 6));
            check("multi_rel_stb", 32'(bus.key_stb), 32'd0);
        end

        // Release bounce on k2: short drop must not release or re-strobe.
        set_keys(8'h04);
        run_loop("rb_press", 8, 6, 8'h00, 8'h04, 6);
        set_keys(8'h00);
        run_loop("rb_drop", 2, 0, 8'h04, 8'h04, 99);
        set_keys(8'h04);
        run_loop("rb_back", 8, 0, 8'h04, 8'h04, 99);
        set_keys(8'h00);
        run_loop("rb_rel", 8, 0, 8'h04, 8'h00, 6);

        // Rollover: k4 held, k7 added, both released, then k7 alone.
        set_keys(8'h10);
        run_loop("ro_k4", 8, 6, 8'h00, 8'h10, 6);
        set_keys(8'h90);
        run_loop("ro_both", 6, 0, 8'h10, 8'h10, 99);
        set_keys(8'h00);
        run_loop("ro_rel", 8, 0, 8'h10, 8'h00, 6);
        set_keys(8'h80);
        run_loop("ro_k7", 8, 6, 8'h00, 8'h80, 6);
        set_keys(8'h00);
        run_loop("ro_k7_rel", 8, 0, 8'h80, 8'h00, 6);

        // Reset mid-press on k1: outputs clear at once, press re-debounced.
        set_keys(8'h02);
        run_loop("rst_press", 8, 6, 8'h00, 8'h02, 6);
        rst_n = 1'b0;
        #1;
        check("rst_mid_c", 32'(c_obs), 32'd0);
        check("rst_mid_stb", 32'(bus.key_stb), 32'd0);
        check("rst_mid_err", 32'(bus.key_err), 32'd0);
        tick();
        check("rst_hold_c", 32'(c_obs), 32'd0);
        rst_n = 1'b1;
        run_loop("rst_again", 8, 6, 8'h00, 8'h02, 6);
        set_keys(8'h00);
        run_loop("rst_again_rel", 8, 0, 8'h02, 8'h00, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
